shift_receiver: RTL and testbench
=================================

Name: shift_receiver

Overview:
- Serial-in/parallel-out receiver for the digital modulation datapath; the receive-side counterpart of the load-and-shift-left transmit register.
- Accepts one frame of WIDTH bits, MSB first, one bit per enabled clock.
- Presents the assembled word on a held parallel output with a one-cycle done pulse.
- A bit counter and a small FSM bound each frame, so the block needs no external bit counting.

Parameters:
- WIDTH, 9, frame length in bits; this is also the parallel output width. Legal range is 2 to 32.
- CNT_W, 5, bit-counter width. It must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame start request; sampled only in IDLE or DONE.
- shEN  input  1  bit strobe; serialIN is sampled on edges where shEN=1 in SHIFT.
- serialIN  input  1  serial data, MSB first.
- parallelOUT  output  WIDTH  last completed word; held until the next frame completes.
- done  output  1  one-cycle pulse; the cycle parallelOUT updates to a new word.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (rst=1 at a rising edge) overrides every other input, including a frame in progress:
  - state=IDLE
  - internal shift register=0
  - bit counter=0
  - parallelOUT=0, done=0, busy=0
- A partial frame is discarded on reset; parallelOUT is cleared, not preserved.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> SHIFT; clear the shift register and the counter.
  - The start edge does not sample serialIN, even if shEN=1.
  - shEN and serialIN are otherwise ignored.
- SHIFT, busy=1:
  - On each edge with shEN=1: shreg <= {shreg[WIDTH-2:0], serialIN}; counter += 1.
  - shEN=0 holds all state, so gaps between bits of any length are legal.
  - start is ignored, with no restart and no error.
  - On the edge that accepts bit number WIDTH (counter==WIDTH-1 and shEN=1): parallelOUT <= {shreg[WIDTH-2:0], serialIN}, done <= 1, counter <= 0, state -> DONE.
- DONE:
  - Lasts exactly one cycle; done=1 and busy=0.
  - start=1 -> SHIFT (back-to-back frame) with the shift register and counter cleared; otherwise -> IDLE.
  - shEN in DONE is ignored.
- done is registered, and high only in the DONE cycle.
- Latency: done and the new parallelOUT are visible in the cycle immediately after the edge sampling the last bit.
- First received bit lands in parallelOUT[WIDTH-1], last bit in parallelOUT[0]. This is bit-exact with a transmitter that loads the word and shifts left, emitting its MSB.
- Minimum frame time is WIDTH+2 cycles, start to done inclusive (start cycle, WIDTH bit cycles, DONE cycle). Back-to-back frames via start in DONE give a period of WIDTH+1 cycles.
- The counter never exceeds WIDTH-1, and no arithmetic wraps.
- parallelOUT changes only on reset or on frame completion.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 and shEN=1 -> parallelOUT=0, done=0, busy=0; state stays IDLE one cycle after rst falls if start=0.
- Basic frame (WIDTH=9):
  - Stimulus: start pulse, then 9 consecutive shEN=1 cycles with serialIN = 1,0,1,1,0,0,1,1,1.
  - Required: busy high for 9 cycles, parallelOUT=9'h167 with done=1 for exactly one cycle, busy=0 in that cycle, IDLE after.
- Gapped strobes:
  - Stimulus: same frame as the basic test, with shEN dropped for 3 cycles after bits 2 and 7, and serialIN toggling during the gaps.
  - Required: parallelOUT=9'h167, done 9 enabled edges after start, no extra bits captured.
- Back-to-back and ignored start:
  - Stimulus: start=1 in the DONE cycle of a 9'h167 frame, second frame 9'h0AA; also pulse start mid-frame.
  - Required: second done exactly 10 cycles after the first, parallelOUT=9'h0AA, the mid-frame start has no effect.
- Reset mid-frame and start-edge bit:
  - Stimulus: assert rst after 5 bits of 9'h1FF; then start with shEN=1 and serialIN=1 on the start edge, followed by the 9 bits of 9'h001.
  - Required: parallelOUT=0 immediately after reset and no done pulse from the aborted frame; the new frame yields parallelOUT=9'h001, proving the start-edge bit was not sampled.
- Hold: after a frame yields 9'h167, leave the block in IDLE with random shEN/serialIN for 50 cycles -> parallelOUT stays 9'h167 and done stays 0.

Source files
------------

// File: rtl/shift_receiver.sv
// Serial-in/parallel-out frame receiver: assembles WIDTH bits, MSB first, into a
// held parallel word and flags each completed word with a one-cycle done pulse.
module shift_receiver #(
   parameter int WIDTH = 9,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             shEN,
   input  logic             serialIN,
   output logic [WIDTH-1:0] parallelOUT,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] bitCnt;
   logic [WIDTH-1:0] nextWord;

   assign nextWord = {shreg[WIDTH-2:0], serialIN};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bitCnt      <= '0;
         parallelOUT <= '0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // The start edge only arms the frame; serialIN is not sampled here.
               if (start) begin
                  state  <= SHIFT;
                  shreg  <= '0;
                  bitCnt <= '0;
                  busy   <= 1'b1;
               end
            end
            SHIFT: begin
               if (shEN) begin
                  shreg <= nextWord;
                  if (bitCnt == CNT_W'(WIDTH - 1)) begin
                     parallelOUT <= nextWord;
                     done        <= 1'b1;
                     bitCnt      <= '0;
                     busy        <= 1'b0;
                     state       <= DONE;
                  end else begin
                     bitCnt <= bitCnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               // A start here chains the next frame with no idle gap.
               if (start) begin
                  state  <= SHIFT;
                  shreg  <= '0;
                  bitCnt <= '0;
                  busy   <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_receiver.sv
// Bench for shift_receiver: directed frames plus random traffic, every cycle
// compared against a frame-level model that accumulates received bits as integers.
module tb_shift_receiver;
   localparam int W = 9;

   logic         clk = 1'b0;
   logic         rst, start, shEN, serialIN;
   logic [W-1:0] parallelOUT;
   logic         done, busy;

   int vectors = 0, miscompares = 0;
   int cyc = 0, lastDone = -1, doneGap = 0, doneCnt = 0;

   // Frame-level model: receiving or not, bits collected so far, value so far.
   bit           mActive = 0;
   int           mN = 0;
   int           mAcc = 0;
   logic [W-1:0] mOut = '0;
   bit           mDone = 0;

   shift_receiver #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .shEN(shEN), .serialIN(serialIN),
      .parallelOUT(parallelOUT), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic e, input logic d);
      rst = r; start = s; shEN = e; serialIN = d;
      @(posedge clk);
      cyc++;
      if (r) begin
         mActive = 0; mN = 0; mAcc = 0; mOut = '0; mDone = 0;
      end else begin
         mDone = 0;
         if (mActive) begin
            if (e) begin
               mAcc = mAcc * 2 + int'(d);
               mN++;
               if (mN == W) begin
                  mOut    = W'(mAcc);
                  mDone   = 1;
                  mActive = 0;
               end
            end
         end else if (s) begin
            mActive = 1; mN = 0; mAcc = 0;
         end
      end
      #1;
      chk("out",  32'(parallelOUT), 32'(mOut));
      chk("done", 32'(done),        32'(mDone));
      chk("busy", 32'(busy),        32'(mActive));
      if (done) begin
         doneCnt++;
         if (lastDone >= 0) doneGap = cyc - lastDone;
         lastDone = cyc;
      end
   endtask

   // Sends a word MSB first; optional 3-cycle gaps after bit numbers g1/g2,
   // optional start pulse in the middle of the frame.
   task automatic sendWord(input logic [W-1:0] w, input int g1, input int g2, input bit poke);
      for (int i = 0; i < W; i++) begin
         step(1'b0, poke && (i == 4), 1'b1, w[W-1-i]);
         if ((i + 1 == g1) || (i + 1 == g2))
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
      end
   endtask

   initial begin
      int c0, d0;
      // Reset with start and shEN held high
      step(1, 1, 1, 1);
      step(1, 1, 1, 1);
      chk("rst_out", 32'(parallelOUT), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      step(0, 0, 0, 0);
      chk("rst_idle", 32'(busy), 32'h0);

      // Basic frame
      step(0, 1, 0, 0);
      sendWord(9'h167, 0, 0, 0);
      chk("basic_word", 32'(parallelOUT), 32'h167);
      chk("basic_done", 32'(done), 32'h1);
      chk("basic_busy", 32'(busy), 32'h0);
      step(0, 0, 0, 0);
      chk("basic_pulse", 32'(done), 32'h0);

      // Gapped strobes
      d0 = doneCnt;
      step(0, 1, 0, 0);
      sendWord(9'h167, 2, 7, 0);
      chk("gap_word", 32'(parallelOUT), 32'h167);
      chk("gap_done", 32'(doneCnt - d0), 32'h1);
      step(0, 0, 0, 0);

      // Mid-frame start ignored, then back-to-back via start in DONE
      step(0, 1, 0, 0);
      sendWord(9'h167, 0, 0, 1);
      chk("b2b_first", 32'(parallelOUT), 32'h167);
      step(0, 1, 1, 1);
      sendWord(9'h0AA, 0, 0, 0);
      chk("b2b_word", 32'(parallelOUT), 32'h0AA);
      chk("b2b_gap", 32'(doneGap), 32'd10);
      step(0, 0, 0, 0);

      // Reset mid-frame, then a start edge carrying shEN=1/serialIN=1
      d0 = doneCnt;
      step(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
      step(1, 0, 0, 0);
      chk("abort_out", 32'(parallelOUT), 32'h0);
      step(0, 0, 1, 1);
      step(0, 0, 0, 0);
      chk("abort_nodone", 32'(doneCnt - d0), 32'h0);
      step(0, 1, 1, 1);
      sendWord(9'h001, 0, 0, 0);
      chk("startbit_word", 32'(parallelOUT), 32'h001);
      step(0, 0, 0, 0);

      // Hold in IDLE under random shEN/serialIN
      step(0, 1, 0, 0);
      sendWord(9'h167, 0, 0, 0);
      step(0, 0, 0, 0);
      d0 = doneCnt;
      for (int i = 0; i < 50; i++) step(0, 0, 1'($urandom), 1'($urandom));
      chk("hold_word", 32'(parallelOUT), 32'h167);
      chk("hold_nodone", 32'(doneCnt - d0), 32'h0);

      // Random traffic, occasional reset
      c0 = doneCnt;
      for (int i = 0; i < 600; i++)
         step(($urandom % 97) == 0, ($urandom % 4) == 0, ($urandom % 3) != 0, 1'($urandom));
      if (doneCnt == c0) chk("rand_frames", 32'(doneCnt - c0), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
